// File: rtl/reg_write_arbiter_pkg.sv
// Shared register-file geometry and helper types for the write arbiter.
package reg_arb_pkg;
  localparam int DW = 8;
  localparam int PW = 4;

  typedef logic [PW:0]   rf_addr_t;
  typedef logic [DW-1:0] rf_data_t;
endpackage

// File: rtl/reg_write_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or after ptr wins.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from ptr upward with wrap; the first hit claims the one-hot grant.
  always_comb begin
    int i;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    i   = 0;
    for (int k = 0; k < N; k++) begin
      i = (int'(ptr) + k) % N;
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin owner of the register file's single write port, with a
// registered write stage and read bypass for the cycle the write is held.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int pw   = reg_arb_pkg::PW,
  parameter int DW   = reg_arb_pkg::DW,
  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][pw:0]     req_addr,
  input  logic [NREQ-1:0][DW-1:0]   req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [GW-1:0]             grant_id,
  output logic                      rf_wr_en,
  output logic [pw:0]               rf_wr_addr,
  output logic [DW-1:0]             rf_dat_in,
  output logic                      err_oob,
  input  logic [pw:0]               rd_addr,
  input  logic [DW-1:0]             rf_rd_data,
  input  logic [DW-1:0]             rf_acc,
  output logic [DW-1:0]             rd_data,
  output logic [DW-1:0]             acc_data
);

  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] ptr_nxt;
  logic [GW-1:0] win_idx;
  logic          accept;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (req_ready),
    .idx (win_idx),
    .any (accept)
  );

  // Pointer moves one past the winner, wrapping at NREQ-1; fixed at 0 for a single requester.
  always_comb begin
    ptr_nxt = '0;
    if (NREQ > 1)
      ptr_nxt = (win_idx == GW'(NREQ - 1)) ? '0 : win_idx + GW'(1);
  end

  // Output register: capture the accepted write, or drop it and flag an out-of-range address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_dat_in  <= '0;
      err_oob    <= 1'b0;
    end else if (accept) begin
      rr_ptr   <= ptr_nxt;
      grant_id <= win_idx;
      if (!req_addr[win_idx][pw]) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= req_addr[win_idx];
        rf_dat_in  <= req_data[win_idx];
        err_oob    <= 1'b0;
      end else begin
        rf_wr_en <= 1'b0;
        err_oob  <= 1'b1;
      end
    end else begin
      rf_wr_en <= 1'b0;
      err_oob  <= 1'b0;
    end
  end

  // Bypass the pending write over stale file data; rd_addr 0 keeps whatever the file returns.
  always_comb begin
    rd_data  = rf_rd_data;
    acc_data = rf_acc;
    if (rf_wr_en && (rd_addr == rf_wr_addr) && (rd_addr != '0))
      rd_data = rf_dat_in;
    if (rf_wr_en && (rf_wr_addr == '0))
      acc_data = rf_dat_in;
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural register file behind it.
module tb_reg_write_arbiter;
  localparam int NREQ = 3;
  localparam int PW   = 4;
  localparam int DW   = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][PW:0]   req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic [1:0]              grant_id;
  logic                    rf_wr_en;
  logic [PW:0]             rf_wr_addr;
  logic [DW-1:0]           rf_dat_in;
  logic                    err_oob;
  logic [PW:0]             rd_addr;
  logic [DW-1:0]           rf_rd_data;
  logic [DW-1:0]           rf_acc;
  logic [DW-1:0]           rd_data;
  logic [DW-1:0]           acc_data;

  logic [DW-1:0] core [16];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(NREQ), .pw(PW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat_in(rf_dat_in),
    .err_oob(err_oob), .rd_addr(rd_addr), .rf_rd_data(rf_rd_data),
    .rf_acc(rf_acc), .rd_data(rd_data), .acc_data(acc_data)
  );

  // Register file model: R0 is the accumulator, read port returns 0 for address 0.
  always @(posedge clk) if (rf_wr_en) core[rf_wr_addr[3:0]] <= rf_dat_in;
  assign rf_rd_data = (rd_addr == '0) ? '0 : core[rd_addr[3:0]];
  assign rf_acc     = core[0];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1; #1; reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    checks++; if ({rf_wr_en, rf_wr_addr, rf_dat_in, grant_id, err_oob, req_ready} !== '0) begin
      errors++; $display("FAIL reset_state got=%h exp=0", {rf_wr_en, rf_wr_addr, rf_dat_in, grant_id, err_oob, req_ready}); end
    reset = 1'b0;
    req_valid = 3'b001; req_addr[0] = 5'd7; req_data[0] = 8'h3C;
    step();
    req_valid = '0;
    checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL reset_pre_hold got=%b exp=1", rf_wr_en); end
    reset = 1'b1; #1;
    checks++; if ({rf_wr_en, rf_wr_addr, rf_dat_in, grant_id} !== '0) begin
      errors++; $display("FAIL reset_async got=%h exp=0", {rf_wr_en, rf_wr_addr, rf_dat_in, grant_id}); end
    step();
    checks++; if (core[7] !== 8'h00) begin errors++; $display("FAIL reset_discard got=%h exp=00", core[7]); end
    reset = 1'b0; #1;
  endtask

  task automatic test_single();
    req_valid = 3'b010; req_addr[1] = 5'd5; req_data[1] = 8'hA7; #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    step();
    req_valid = '0;
    checks++; if ({rf_wr_en, rf_wr_addr, rf_dat_in, grant_id} !== {1'b1, 5'd5, 8'hA7, 2'd1}) begin
      errors++; $display("FAIL single_out got=%b/%h/%h/%0d exp=1/05/a7/1", rf_wr_en, rf_wr_addr, rf_dat_in, grant_id); end
    step();
    checks++; if (core[5] !== 8'hA7 || rf_wr_en !== 1'b0) begin
      errors++; $display("FAIL single_commit got=%h/%b exp=a7/0", core[5], rf_wr_en); end
  endtask

  task automatic test_round_robin();
    int cnt [NREQ];
    logic [1:0] exp_id;
    rst_pulse();
    for (int r = 0; r < NREQ; r++) begin
      req_addr[r] = 5'(10 + r); req_data[r] = 8'(8'h10 * (r + 1)); cnt[r] = 0;
    end
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp_id = 2'(c % 3); #1;
      checks++; if (req_ready !== 3'(1 << exp_id)) begin
        errors++; $display("FAIL rr_ready cyc=%0d got=%b exp_idx=%0d", c, req_ready, exp_id); end
      step();
      checks++; if (grant_id !== exp_id || rf_dat_in !== 8'(8'h10 * (exp_id + 1))) begin
        errors++; $display("FAIL rr_grant cyc=%0d got=%0d/%h exp=%0d", c, grant_id, rf_dat_in, exp_id); end
      cnt[grant_id]++;
    end
    req_valid = '0;
    checks++; if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2) begin
      errors++; $display("FAIL rr_fair got=%0d,%0d,%0d exp=2,2,2", cnt[0], cnt[1], cnt[2]); end
    step();
  endtask

  task automatic test_bypass();
    req_valid = 3'b001; req_addr[0] = 5'd3; req_data[0] = 8'h55;
    step();
    req_valid = '0; rd_addr = 5'd3; #1;
    checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL bypass_rd got=%h exp=55", rd_data); end
    checks++; if (acc_data !== 8'h00) begin errors++; $display("FAIL bypass_acc_quiet got=%h exp=00", acc_data); end
    req_valid = 3'b001; req_addr[0] = 5'd0; req_data[0] = 8'h9E;
    step();
    req_valid = '0; rd_addr = 5'd0; #1;
    checks++; if (acc_data !== 8'h9E) begin errors++; $display("FAIL bypass_acc got=%h exp=9e", acc_data); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL bypass_r0_read got=%h exp=00", rd_data); end
    step();
    rd_addr = 5'd3; #1;
    checks++; if (rd_data !== 8'h55 || acc_data !== 8'h9E) begin
      errors++; $display("FAIL bypass_after got=%h/%h exp=55/9e", rd_data, acc_data); end
  endtask

  task automatic test_oob();
    req_valid = 3'b100; req_addr[2] = 5'b1_0010; req_data[2] = 8'hFF; #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL oob_ready got=%b exp=100", req_ready); end
    step();
    req_valid = '0;
    checks++; if ({rf_wr_en, err_oob, grant_id} !== {1'b0, 1'b1, 2'd2}) begin
      errors++; $display("FAIL oob_flag got=%b/%b/%0d exp=0/1/2", rf_wr_en, err_oob, grant_id); end
    step();
    checks++; if (err_oob !== 1'b0 || core[2] !== 8'h00) begin
      errors++; $display("FAIL oob_pulse got=%b/%h exp=0/00", err_oob, core[2]); end
    req_valid = 3'b111; #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL oob_ptr got=%b exp=001", req_ready); end
    req_valid = '0; #1;
  endtask

  task automatic test_idle();
    req_valid = 3'b010; req_addr[1] = 5'd9; req_data[1] = 8'h12;
    step();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if ({rf_wr_en, rf_wr_addr, rf_dat_in} !== {1'b0, 5'd9, 8'h12}) begin
        errors++; $display("FAIL idle_hold cyc=%0d got=%b/%h/%h exp=0/09/12", c, rf_wr_en, rf_wr_addr, rf_dat_in); end
    end
    req_valid = 3'b111; #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL idle_ptr got=%b exp=100", req_ready); end
    req_valid = '0; #1;
  endtask

  task automatic test_back_to_back();
    rst_pulse();
    req_valid = 3'b011;
    req_addr[0] = 5'd6; req_data[0] = 8'h11;
    req_addr[1] = 5'd6; req_data[1] = 8'h22;
    step();
    req_valid = 3'b010;
    step();
    req_valid = '0; rd_addr = 5'd6; #1;
    checks++; if (rd_data !== 8'h22 || grant_id !== 2'd1) begin
      errors++; $display("FAIL b2b_bypass got=%h/%0d exp=22/1", rd_data, grant_id); end
    step();
    checks++; if (core[6] !== 8'h22) begin errors++; $display("FAIL b2b_commit got=%h exp=22", core[6]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) core[i] = '0;
    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; rd_addr = '0;
    #2;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_bypass();
    test_oob();
    test_idle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
